// File: rtl/display_pkg.sv
// Segment codes and digit encoder for the common-anode 7-segment display.
// All codes are active-low, with bit order {g,f,e,d,c,b,a}.
package display_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan divider; tick_o pulses for one cycle when the counter is all ones.
module scan_tick_gen #(
  parameter int DIV_BITS = 17
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);
  logic [DIV_BITS-1:0] cnt_q, cnt_d;

  assign cnt_d  = cnt_q + DIV_BITS'(1);
  assign tick_o = &cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_display_mux.sv
// 4-digit multiplexed decimal display of an 8-bit value, with leading-zero blanking.
// Each scan is decoded from a single snapshot that is taken as the scan starts.
module seg_display_mux
  import display_pkg::*;
#(
  parameter int DIV_BITS = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  output logic [3:0] an,
  output logic [6:0] segs
);
  logic       tick;
  logic [1:0] idx_q, idx_d;
  logic [7:0] snap_q, src;
  logic [3:0] an_q, an_d;
  logic [6:0] segs_q, segs_d;
  logic [3:0] hund, tens, ones;

  scan_tick_gen #(.DIV_BITS(DIV_BITS)) u_tick (
    .clk_i (clk),
    .rst_i (rst),
    .tick_o(tick)
  );

  assign idx_d = idx_q + 2'd1;
  // On the capture tick, decode from value itself so digit 0 matches the new snapshot.
  assign src   = (idx_d == 2'd0) ? value : snap_q;
  assign hund  = 4'(src / 8'd100);
  assign tens  = 4'((src / 8'd10) % 8'd10);
  assign ones  = 4'(src % 8'd10);
  assign an_d  = ~(4'b0001 << idx_d);

  always_comb begin
    segs_d = SEG_BLANK;
    case (idx_d)
      2'd0: segs_d = seg_encode(ones);
      2'd1: segs_d = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_encode(tens);
      2'd2: segs_d = (hund == 4'd0) ? SEG_BLANK : seg_encode(hund);
      default: segs_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 2'd3;
      snap_q <= 8'd0;
      an_q   <= AN_OFF;
      segs_q <= SEG_BLANK;
    end else if (tick) begin
      idx_q  <= idx_d;
      an_q   <= an_d;
      segs_q <= segs_d;
      if (idx_d == 2'd0) snap_q <= value;
    end
  end

  assign an   = an_q;
  assign segs = segs_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux with DIV_BITS=2 (a digit advances every 4 cycles).
module tb_seg_display_mux;
  typedef struct {
    logic [3:0] an;
    logic [6:0] segs;
    int         gap;   // expected cycles since the previous an change; 0 = unchecked
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic [3:0] an;
  logic [6:0] segs;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   done   = 1'b0;

  seg_display_mux #(.DIV_BITS(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .value(value),
    .an   (an),
    .segs (segs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of an is a new digit presentation.
  logic [3:0] prev_an   = 4'b1111;
  logic [6:0] prev_segs = 7'h7F;
  int         last_cyc  = 0;
  always @(negedge clk) begin
    if (!done && !$isunknown(an)) begin
      if (an !== prev_an) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update: an=%b segs=%h with empty queue", an, segs);
        end else begin
          e = exp_q.pop_front();
          if (an !== e.an || segs !== e.segs) begin
            errors++;
            $display("FAIL digit: got an=%b segs=%h, want an=%b segs=%h", an, segs, e.an, e.segs);
          end
          if (e.gap != 0) begin
            checks++;
            if (cyc - last_cyc != e.gap) begin
              errors++;
              $display("FAIL tick_gap: got %0d cycles, want %0d", cyc - last_cyc, e.gap);
            end
          end
        end
        last_cyc = cyc;
      end else begin
        checks++;
        if (segs !== prev_segs) begin
          errors++;
          $display("FAIL hold: segs changed to %h without an change, want %h", segs, prev_segs);
        end
      end
      prev_an   = an;
      prev_segs = segs;
    end
  end

  task automatic push(input logic [3:0] a, input logic [6:0] s, input int g);
    exp_t e;
    e.an = a; e.segs = s; e.gap = g;
    exp_q.push_back(e);
  endtask

  // One 16-cycle scan window starting at a negedge; capture happens on its 4th edge.
  // value switches to v_late after the 9th edge, while digit 1 is being shown.
  task automatic scan(input logic [7:0] v, input logic [7:0] v_late,
                      input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3, input int g0);
    value = v;
    push(4'b1110, s0, g0);
    push(4'b1101, s1, 4);
    push(4'b1011, s2, 4);
    push(4'b0111, s3, 4);
    repeat (9) @(posedge clk);
    @(negedge clk) value = v_late;
    repeat (7) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    value = 8'd123;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (an !== 4'b1111 || segs !== 7'h7F) begin
        errors++;
        $display("FAIL reset_state: an=%b segs=%h, want an=1111 segs=7f", an, segs);
      end
    end
    rst = 1'b0;
    scan(8'd123, 8'd123, 7'h30, 7'h24, 7'h79, 7'h7F, 0);
    scan(8'd255, 8'd255, 7'h12, 7'h12, 7'h24, 7'h7F, 4);
    scan(8'd7,   8'd7,   7'h78, 7'h7F, 7'h7F, 7'h7F, 4);
    scan(8'd0,   8'd0,   7'h40, 7'h7F, 7'h7F, 7'h7F, 4);
    scan(8'd105, 8'd105, 7'h12, 7'h40, 7'h79, 7'h7F, 4);
    scan(8'd42,  8'd99,  7'h24, 7'h19, 7'h7F, 7'h7F, 4);
    scan(8'd99,  8'd99,  7'h10, 7'h10, 7'h7F, 7'h7F, 4);

    // Reset while digit 2 is lit; scanning restarts at digit 0 four cycles later.
    value = 8'd200;
    push(4'b1110, 7'h40, 4);
    push(4'b1101, 7'h40, 4);
    push(4'b1011, 7'h24, 4);
    push(4'b1111, 7'h7F, 1);
    repeat (12) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++)
      scan(8'd200, 8'd200, 7'h40, 7'h40, 7'h24, 7'h7F, 4);

    repeat (4) @(negedge clk);
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expected updates never seen, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
